usr_serializer: RTL and testbench

USR_SERIALIZER -- requirements
Module: usr_serializer

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_serializer_if.sv | 41 ++++
 rtl/usr_bit_counter.sv | 37 +++
 rtl/usr_serializer.sv | 90 +++++++++
 tb/tb_usr_serializer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal-shift-register family: mode codes and the
// serializer state encoding.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // LSB-first frames feed the register's MSB end, so they need a right shift.
    function automatic logic [1:0] mode_for_dir(input logic msb_first);
        return msb_first ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/usr_serializer_if.sv
// Load handshake plus serial/control outputs of usr_serializer, bundled for
// the producer (master) and the serializer (slave).
interface usr_serializer_if #(
    parameter int unsigned WIDTH = 8
);

    logic [WIDTH-1:0] data_in;
    logic             dir;
    logic             load_valid;
    logic             load_ready;
    logic             serial_out;
    logic [1:0]       select_out;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output data_in,
        output dir,
        output load_valid,
        input  load_ready,
        input  serial_out,
        input  select_out,
        input  frame_start,
        input  frame_end,
        input  busy
    );

    modport slave (
        input  data_in,
        input  dir,
        input  load_valid,
        output load_ready,
        output serial_out,
        output select_out,
        output frame_start,
        output frame_end,
        output busy
    );

endinterface

// File: rtl/usr_bit_counter.sv
// Bit-position counter for one serial frame; wraps to zero only after the last bit.
module usr_bit_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [CW-1:0] count_q, count_d;

    assign last  = (count_q == CW'(WIDTH - 1));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (en) begin
            count_d = last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/usr_serializer.sv
// Parallel-to-serial converter that drives a downstream universal shift register:
// one bit per cycle, LSB or MSB first, with back-to-back frame support.
module usr_serializer
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic           CLK,
    input  logic           clear,
    usr_serializer_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic             dir_q;
    logic [CW-1:0]    count;
    logic             last;
    logic             accept;
    logic             shifting;

    assign accept   = bus.load_valid && bus.load_ready;
    assign shifting = (state_q == SHIFT);

    usr_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .CLK   (CLK),
        .clear (clear),
        .start (accept),
        .en    (shifting),
        .count (count),
        .last  (last)
    );

    always_ff @(posedge CLK) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready  = 1'b0;
        bus.serial_out  = 1'b0;
        bus.select_out  = MODE_HOLD;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.busy        = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.load_ready = 1'b1;
            end
            SHIFT: begin
                bus.load_ready  = last;
                bus.busy        = 1'b1;
                bus.serial_out  = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];
                bus.select_out  = mode_for_dir(dir_q);
                bus.frame_start = (count == '0);
                bus.frame_end   = last;
            end
            default: ;
        endcase
    end

    // A load on the last-bit cycle overrides the shift, giving gapless frames.
    always_ff @(posedge CLK) begin
        if (clear) begin
            shreg_q <= '0;
            dir_q   <= 1'b0;
        end else if (accept) begin
            shreg_q <= bus.data_in;
            dir_q   <= bus.dir;
        end else if (shifting) begin
            shreg_q <= dir_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_usr_serializer.sv
// Self-checking bench for usr_serializer: directed frames plus random traffic,
// compared cycle by cycle against a queue of expected serial bits.
module tb_usr_serializer;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic       b;
        logic       fs;
        logic       fe;
        logic [1:0] mode;
    } bit_rec_t;

    logic     CLK;
    logic     clear;
    int       checks;
    int       errors;
    bit_rec_t exp_q[$];
    logic [15:0] cap;
    int       cap_n;
    logic [W-1:0] usr_reg;
    logic [W-1:0] word;

    usr_serializer_if #(.WIDTH(W)) bus ();

    usr_serializer #(
        .WIDTH (W)
    ) dut (
        .CLK   (CLK),
        .clear (clear),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Downstream universal shift register fed by the serializer.
    always_ff @(posedge CLK) begin
        case (bus.select_out)
            2'b01:   usr_reg <= {bus.serial_out, usr_reg[W-1:1]};
            2'b10:   usr_reg <= {usr_reg[W-2:0], bus.serial_out};
            default: usr_reg <= usr_reg;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w, input logic d);
        bit_rec_t r;
        for (int i = 0; i < int'(W); i++) begin
            r.b    = d ? w[W-1-i] : w[i];
            r.fs   = (i == 0);
            r.fe   = (i == int'(W) - 1);
            r.mode = d ? 2'b10 : 2'b01;
            exp_q.push_back(r);
        end
    endtask

    task automatic check_outputs();
        bit_rec_t f;
        if (exp_q.size() == 0) begin
            chk("idle_ready",  32'(bus.load_ready),  32'd1);
            chk("idle_busy",   32'(bus.busy),        32'd0);
            chk("idle_serial", 32'(bus.serial_out),  32'd0);
            chk("idle_select", 32'(bus.select_out),  32'd0);
            chk("idle_fstart", 32'(bus.frame_start), 32'd0);
            chk("idle_fend",   32'(bus.frame_end),   32'd0);
        end else begin
            f = exp_q[0];
            chk("shift_ready",  32'(bus.load_ready),  32'(exp_q.size() == 1));
            chk("shift_busy",   32'(bus.busy),        32'd1);
            chk("shift_serial", 32'(bus.serial_out),  32'(f.b));
            chk("shift_select", 32'(bus.select_out),  32'(f.mode));
            chk("shift_fstart", 32'(bus.frame_start), 32'(f.fs));
            chk("shift_fend",   32'(bus.frame_end),   32'(f.fe));
        end
    endtask

    // One clock: check what is presented now, drive inputs, advance the model.
    task automatic cycle(input logic lv, input logic [W-1:0] w, input logic d, input logic clr);
        logic rdy;
        check_outputs();
        if (bus.busy === 1'b1) begin
            cap = {cap[14:0], bus.serial_out};
            cap_n++;
        end
        bus.load_valid = lv;
        bus.data_in    = w;
        bus.dir        = d;
        clear          = clr;
        rdy = (exp_q.size() <= 1);
        if (clr) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (lv && rdy) push_frame(w, d);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cap    = '0;
        cap_n  = 0;
        bus.load_valid = 1'b0;
        bus.data_in    = '0;
        bus.dir        = 1'b0;
        clear          = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        clear = 1'b0;

        // Reset state, then A6 LSB first.
        cap = '0; cap_n = 0;
        cycle(1'b1, 8'hA6, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 8'hA6, 1'b0, 1'b0);
        chk("a6_lsb_seq", 32'(cap[7:0]), 32'h65);
        chk("a6_lsb_len", 32'(cap_n), 32'd8);
        chk("usr_lsb",    32'(usr_reg), 32'hA6);

        // A6 MSB first.
        cap = '0; cap_n = 0;
        cycle(1'b1, 8'hA6, 1'b1, 1'b0);
        repeat (8) cycle(1'b0, 8'hA6, 1'b1, 1'b0);
        chk("a6_msb_seq", 32'(cap[7:0]), 32'hA6);
        chk("a6_msb_len", 32'(cap_n), 32'd8);
        chk("usr_msb",    32'(usr_reg), 32'hA6);

        // Back-to-back 3C then C3 with load_valid held.
        cap = '0; cap_n = 0;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (8) cycle(1'b1, 8'hC3, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("b2b_seq", 32'(cap), 32'h3CC3);
        chk("b2b_len", 32'(cap_n), 32'd16);
        chk("b2b_usr", 32'(usr_reg), 32'hC3);

        // Inputs churn during the frame; the latched word must survive.
        for (int k = 0; k < 4; k++) begin
            logic d;
            word = 8'($urandom);
            d    = 1'($urandom);
            cycle(1'b1, word, d, 1'b0);
            repeat (8) cycle(1'b0, 8'($urandom), 1'($urandom), 1'b0);
            chk("toggle_usr", 32'(usr_reg), 32'(word));
        end

        // Clear on the 4th bit of FF aborts the frame.
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 8'hFF, 1'b0, 1'b0);
        cycle(1'b0, 8'hFF, 1'b0, 1'b1);
        chk("clr_serial", 32'(bus.serial_out), 32'd0);
        chk("clr_select", 32'(bus.select_out), 32'd0);
        chk("clr_ready",  32'(bus.load_ready), 32'd1);
        chk("clr_busy",   32'(bus.busy),       32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // load_valid during clear is ignored.
        cycle(1'b1, 8'h5A, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr_lv_busy", 32'(bus.busy), 32'd0);

        // Random traffic with occasional clears.
        repeat (400) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                  1'($urandom_range(0, 63) == 0));
        end
        repeat (10) cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
